exec_unit: RTL and testbench

Parametrised multi-cycle integer execute unit with a private register file. It accepts one RV32I-style R-type or I-type ALU instruction per valid/ready handshake, then reads operands, computes the result, and writes it back to `rd`. It presents the result on a valid/ready output port. It is the successor to the fixed 3-state add/subtract datapath: it adds configurable width and register count, the full OP/OP-IMM ALU set, sign-extended immediates, a hardwired x0, illegal-instruction reporting, and flow control on both sides.

---
 rtl/exec_unit.sv | 147 ++++++++++++++
 tb/tb_exec_unit.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/exec_unit.sv
// exec_unit: multi-cycle RV32I-style OP/OP-IMM execute unit with a private register file.
// Flow: IDLE (accept) -> READ (operands, legality) -> EXEC (ALU, writeback) -> DONE (report).
module exec_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned NREGS = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic             funct7b5,
  input  logic [4:0]       rd,
  input  logic [4:0]       rs1,
  input  logic [4:0]       rs2,
  input  logic [11:0]      imm12,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [4:0]       out_rd,
  output logic             illegal,
  output logic [7:0]       led
);

  localparam int unsigned AW = $clog2(NREGS);
  localparam int unsigned SW = $clog2(WIDTH);
  localparam logic [6:0] OPC_OP  = 7'b0110011;
  localparam logic [6:0] OPC_IMM = 7'b0010011;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC, S_DONE} state_t;

  state_t           state, state_next;
  logic [6:0]       opc_q;
  logic [2:0]       f3_q;
  logic             f7_q;
  logic [4:0]       rd_q, rs1_q, rs2_q;
  logic [11:0]      imm_q;
  logic [WIDTH-1:0] op_a, op_b;
  logic             ill_q;
  logic [WIDTH-1:0] rf [NREGS];

  logic             is_op_c, is_imm_c, ill_c;
  logic [WIDTH-1:0] rd_a_c, rd_b_c, alu_c;
  logic [SW-1:0]    shamt_c;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (in_valid) state_next = S_READ;
      S_READ:  state_next = S_EXEC;
      S_EXEC:  state_next = S_DONE;
      S_DONE:  if (out_ready) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Operand read with hardwired x0, plus legality decode of the latched instruction
  always_comb begin
    is_op_c  = (opc_q == OPC_OP);
    is_imm_c = (opc_q == OPC_IMM);
    rd_a_c   = (rs1_q == 5'd0) ? '0 : rf[rs1_q[AW-1:0]];
    rd_b_c   = (rs2_q == 5'd0) ? '0 : rf[rs2_q[AW-1:0]];
    ill_c    = 1'b0;
    if (!is_op_c && !is_imm_c) ill_c = 1'b1;
    if (is_op_c && f7_q && (f3_q != 3'b000) && (f3_q != 3'b101)) ill_c = 1'b1;
    if (is_imm_c && f7_q && (f3_q == 3'b001)) ill_c = 1'b1;
    if ((32'(rd_q) >= NREGS) || (32'(rs1_q) >= NREGS)) ill_c = 1'b1;
    if (is_op_c && (32'(rs2_q) >= NREGS)) ill_c = 1'b1;
  end

  // ALU on the latched operands
  always_comb begin
    shamt_c = op_b[SW-1:0];
    alu_c   = '0;
    case (f3_q)
      3'b000:  alu_c = (is_op_c && f7_q) ? (op_a - op_b) : (op_a + op_b);
      3'b001:  alu_c = op_a << shamt_c;
      3'b010:  alu_c = WIDTH'($signed(op_a) < $signed(op_b));
      3'b011:  alu_c = WIDTH'(op_a < op_b);
      3'b100:  alu_c = op_a ^ op_b;
      3'b101:  alu_c = f7_q ? WIDTH'($signed(op_a) >>> shamt_c) : (op_a >> shamt_c);
      3'b110:  alu_c = op_a | op_b;
      default: alu_c = op_a & op_b;
    endcase
  end

  // Datapath, register file and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_rd    <= '0;
      illegal   <= 1'b0;
      led       <= '0;
      opc_q     <= '0;
      f3_q      <= '0;
      f7_q      <= 1'b0;
      rd_q      <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      imm_q     <= '0;
      op_a      <= '0;
      op_b      <= '0;
      ill_q     <= 1'b0;
      for (int i = 0; i < int'(NREGS); i++) rf[i] <= '0;
    end else begin
      in_ready  <= (state_next == S_IDLE);
      out_valid <= (state_next == S_DONE);
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            opc_q <= opcode;
            f3_q  <= funct3;
            f7_q  <= funct7b5;
            rd_q  <= rd;
            rs1_q <= rs1;
            rs2_q <= rs2;
            imm_q <= imm12;
          end
        end
        S_READ: begin
          op_a  <= rd_a_c;
          op_b  <= is_op_c ? rd_b_c : WIDTH'($signed(imm_q));
          ill_q <= ill_c;
        end
        S_EXEC: begin
          out_data <= ill_q ? '0 : alu_c;
          led      <= ill_q ? 8'd0 : alu_c[7:0];
          out_rd   <= rd_q;
          illegal  <= ill_q;
          if (!ill_q && (rd_q != 5'd0)) rf[rd_q[AW-1:0]] <= alu_c;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_exec_unit.sv
// Directed bench for exec_unit: vector table plus stall and reset-in-flight sequences.
module tb_exec_unit;

  localparam logic [6:0] OP  = 7'b0110011;
  localparam logic [6:0] IMM = 7'b0010011;

  logic        clk, reset, in_valid, out_ready, funct7b5;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [4:0]  rd, rs1, rs2;
  logic [11:0] imm12;
  logic        in_ready, out_valid, illegal;
  logic [31:0] out_data;
  logic [4:0]  out_rd;
  logic [7:0]  led;
  logic        in_ready8, out_valid8, illegal8;
  logic [31:0] out_data8;
  logic [4:0]  out_rd8;
  logic [7:0]  led8;

  int n_cmp = 0;
  int n_bad = 0;

  exec_unit #(.WIDTH(32), .NREGS(32)) u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5), .rd(rd), .rs1(rs1), .rs2(rs2),
    .imm12(imm12), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_rd(out_rd), .illegal(illegal), .led(led)
  );

  // Second instance with 8 registers runs in lockstep on the same stimulus
  exec_unit #(.WIDTH(32), .NREGS(8)) u_dut8 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready8),
    .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5), .rd(rd), .rs1(rs1), .rs2(rs2),
    .imm12(imm12), .out_valid(out_valid8), .out_ready(out_ready), .out_data(out_data8),
    .out_rd(out_rd8), .illegal(illegal8), .led(led8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic        f7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [11:0] imm;
    logic [31:0] exp;
    logic        ill;
  } vec_t;

  function automatic vec_t mk(input logic [6:0] opc, input logic [2:0] f3, input logic f7,
                              input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                              input logic [11:0] imm, input logic [31:0] exp, input logic ill);
    vec_t v;
    v.opc = opc; v.f3 = f3; v.f7 = f7; v.rd = d; v.rs1 = s1; v.rs2 = s2;
    v.imm = imm; v.exp = exp; v.ill = ill;
    return v;
  endfunction

  function automatic vec_t r_op(input logic [2:0] f3, input logic f7, input logic [4:0] d,
                                input logic [4:0] s1, input logic [4:0] s2, input logic [31:0] exp);
    return mk(OP, f3, f7, d, s1, s2, 12'h000, exp, 1'b0);
  endfunction

  function automatic vec_t i_op(input logic [2:0] f3, input logic f7, input logic [4:0] d,
                                input logic [4:0] s1, input logic [11:0] imm, input logic [31:0] exp);
    return mk(IMM, f3, f7, d, s1, 5'd0, imm, exp, 1'b0);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Issue one instruction, check latency and outputs, optionally stall DONE for hold cycles
  task automatic run(input string tag, input vec_t v, input int hold);
    int n;
    logic ill8;
    ill8 = v.ill || (v.rd >= 5'd8) || (v.rs1 >= 5'd8) || ((v.opc == OP) && (v.rs2 >= 5'd8));
    chk({tag, " in_ready before issue"}, 64'(in_ready), 64'd1);
    opcode = v.opc; funct3 = v.f3; funct7b5 = v.f7; rd = v.rd; rs1 = v.rs1; rs2 = v.rs2;
    imm12 = v.imm; in_valid = 1'b1; out_ready = (hold == 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    opcode = 7'h7F; funct3 = 3'h7; funct7b5 = 1'b1; rd = 5'd31; rs1 = 5'd31; rs2 = 5'd31;
    imm12 = 12'hABC;
    n = 1;
    chk({tag, " in_ready busy"}, 64'(in_ready), 64'd0);
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, " latency"}, 64'(n), 64'd3);
    chk({tag, " out_data"}, 64'(out_data), 64'(v.exp));
    chk({tag, " illegal"}, 64'(illegal), 64'(v.ill));
    chk({tag, " out_rd"}, 64'(out_rd), 64'(v.rd));
    chk({tag, " led"}, 64'(led), 64'(v.exp[7:0]));
    chk({tag, " illegal nregs8"}, 64'(illegal8), 64'(ill8));
    for (int k = 0; k < hold; k++) begin
      in_valid = 1'b1;
      opcode = IMM; funct3 = 3'b000; rd = 5'd1; rs1 = 5'd0; imm12 = 12'h055;
      @(posedge clk); #1;
      chk($sformatf("%s stall%0d out_valid", tag, k), 64'(out_valid), 64'd1);
      chk($sformatf("%s stall%0d out_data", tag, k), 64'(out_data), 64'(v.exp));
      chk($sformatf("%s stall%0d in_ready", tag, k), 64'(in_ready), 64'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk({tag, " in_ready after handshake"}, 64'(in_ready), 64'd1);
    chk({tag, " out_valid after handshake"}, 64'(out_valid), 64'd0);
    chk({tag, " out_data held"}, 64'(out_data), 64'(v.exp));
  endtask

  vec_t vt[$];

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    opcode = '0; funct3 = '0; funct7b5 = 1'b0; rd = '0; rs1 = '0; rs2 = '0; imm12 = '0;

    vt.push_back(i_op(3'b000, 1'b0, 5'd1,  5'd0, 12'h005, 32'h0000_0005));  // ADDI x1,x0,5
    vt.push_back(i_op(3'b000, 1'b0, 5'd2,  5'd0, 12'hFFD, 32'hFFFF_FFFD));  // ADDI x2,x0,-3
    vt.push_back(r_op(3'b000, 1'b1, 5'd3,  5'd1, 5'd2,    32'h0000_0008));  // SUB
    vt.push_back(r_op(3'b010, 1'b0, 5'd4,  5'd2, 5'd1,    32'h0000_0001));  // SLT
    vt.push_back(r_op(3'b011, 1'b0, 5'd5,  5'd2, 5'd1,    32'h0000_0000));  // SLTU
    vt.push_back(i_op(3'b101, 1'b1, 5'd6,  5'd2, 12'h001, 32'hFFFF_FFFE));  // SRAI
    vt.push_back(i_op(3'b101, 1'b0, 5'd7,  5'd2, 12'h01C, 32'h0000_000F));  // SRLI 28
    vt.push_back(i_op(3'b000, 1'b0, 5'd9,  5'd0, 12'h021, 32'h0000_0021));  // x9 = 33
    vt.push_back(r_op(3'b001, 1'b0, 5'd10, 5'd1, 5'd9,    32'h0000_000A));  // SLL by 33
    vt.push_back(i_op(3'b000, 1'b0, 5'd0,  5'd0, 12'h007, 32'h0000_0007));  // ADDI x0,x0,7
    vt.push_back(r_op(3'b000, 1'b0, 5'd8,  5'd0, 5'd0,    32'h0000_0000));  // ADD x8,x0,x0
    vt.push_back(mk(7'b0110111, 3'b000, 1'b0, 5'd1, 5'd1, 5'd0, 12'h001, 32'h0, 1'b1));
    vt.push_back(i_op(3'b000, 1'b0, 5'd0,  5'd1, 12'h000, 32'h0000_0005));  // x1 unchanged
    vt.push_back(mk(OP, 3'b100, 1'b1, 5'd2, 5'd1, 5'd1, 12'h000, 32'h0, 1'b1));  // SUB-coded XOR
    vt.push_back(i_op(3'b000, 1'b0, 5'd0,  5'd2, 12'h000, 32'hFFFF_FFFD));  // x2 unchanged
    vt.push_back(r_op(3'b110, 1'b0, 5'd11, 5'd1, 5'd2,    32'hFFFF_FFFD));  // OR
    vt.push_back(r_op(3'b111, 1'b0, 5'd12, 5'd1, 5'd2,    32'h0000_0005));  // AND
    vt.push_back(i_op(3'b100, 1'b0, 5'd13, 5'd1, 12'hFFF, 32'hFFFF_FFFA));  // XORI -1
    vt.push_back(i_op(3'b010, 1'b0, 5'd14, 5'd2, 12'hFFE, 32'h0000_0001));  // SLTI -3<-2
    vt.push_back(i_op(3'b011, 1'b0, 5'd15, 5'd1, 12'hFFF, 32'h0000_0001));  // SLTIU
    vt.push_back(r_op(3'b101, 1'b1, 5'd16, 5'd2, 5'd1,    32'hFFFF_FFFF));  // SRA by 5
    vt.push_back(r_op(3'b101, 1'b0, 5'd17, 5'd2, 5'd1,    32'h07FF_FFFF));  // SRL by 5
    vt.push_back(i_op(3'b111, 1'b0, 5'd18, 5'd2, 12'h0F0, 32'h0000_00F0));  // ANDI
    vt.push_back(mk(IMM, 3'b001, 1'b1, 5'd19, 5'd1, 5'd0, 12'h001, 32'h0, 1'b1));  // SLLI f7b5
    vt.push_back(i_op(3'b000, 1'b1, 5'd19, 5'd1, 12'h001, 32'h0000_0006));  // ADDI ignores f7b5
    vt.push_back(i_op(3'b000, 1'b0, 5'd0,  5'd19, 12'h000, 32'h0000_0006)); // read x19
    vt.push_back(i_op(3'b000, 1'b0, 5'd0,  5'd4, 12'h000, 32'h0000_0001));  // read x4

    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("reset in_ready", 64'(in_ready), 64'd1);
    chk("reset out_valid", 64'(out_valid), 64'd0);
    chk("reset out_data", 64'(out_data), 64'd0);
    chk("reset out_rd", 64'(out_rd), 64'd0);
    chk("reset illegal", 64'(illegal), 64'd0);
    chk("reset led", 64'(led), 64'd0);

    for (int i = 0; i < vt.size(); i++) run($sformatf("v%0d", i), vt[i], 0);

    // DONE held for 10 cycles with out_ready low
    run("stall", i_op(3'b000, 1'b0, 5'd20, 5'd1, 12'h002, 32'h0000_0007), 10);
    run("read x20", i_op(3'b000, 1'b0, 5'd0, 5'd20, 12'h000, 32'h0000_0007), 0);

    // Reset during EXEC of ADDI x1,x1,1
    opcode = IMM; funct3 = 3'b000; funct7b5 = 1'b0; rd = 5'd1; rs1 = 5'd1; rs2 = 5'd0;
    imm12 = 12'h001; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("midreset out_valid", 64'(out_valid), 64'd0);
    chk("midreset in_ready", 64'(in_ready), 64'd1);
    chk("midreset out_data", 64'(out_data), 64'd0);
    chk("midreset led", 64'(led), 64'd0);
    repeat (3) begin
      @(posedge clk); #1;
      chk("midreset no late out_valid", 64'(out_valid), 64'd0);
    end
    run("post-reset x1", i_op(3'b000, 1'b0, 5'd0, 5'd1, 12'h000, 32'h0), 0);
    run("post-reset x2", i_op(3'b000, 1'b0, 5'd0, 5'd2, 12'h000, 32'h0), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
